// File: rtl/program_loader.sv
// Boot loader: assembles LE 32-bit words from a byte stream, writes them to main memory, verifies an XOR checksum.
// Latency: one cycle from the 4th byte of a word to its mem_wen pulse; cpu_run/error update on the deciding byte's edge.
// Backpressure: in_ready is high while loading (LEN/DATA/CSUM), low once DONE or ERROR until reload.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   in_valid/in_data/in_ready byte stream handshake
//   reload                    restart request, honoured only in DONE or ERROR
//   mem_wen/mem_waddr/mem_wdata  main-memory write port (one-cycle pulse per word)
//   cpu_run                   cpu active-low reset; 1 only after a clean load
//   error                     sticky length/checksum failure
//   words_loaded              words written in the current load
module program_loader #(
    parameter int DEPTH     = 2048,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        reload,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        cpu_run,
    output logic        error,
    output logic [31:0] words_loaded
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [31:0] BASE_W  = 32'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  byte_cnt;
    logic [23:0] partial;     // bytes 0..2 of the word being assembled
    logic [31:0] len;
    logic [31:0] acc;

    logic        take;
    logic        last_byte;
    logic [31:0] word;

    // The completed word is only meaningful on the edge that takes byte 3.
    assign word = {in_data, partial};

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        take      = 1'b0;
        last_byte = 1'b0;

        in_ready  = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
        take      = in_valid && in_ready;
        last_byte = take && (byte_cnt == 2'd3);

        case (state)
            S_LEN: begin
                if (last_byte) begin
                    if (word > DEPTH_W)
                        state_nxt = S_ERROR;
                    else if (word == 32'd0)
                        state_nxt = S_CSUM;
                    else
                        state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (last_byte && (words_loaded + 32'd1 == len))
                    state_nxt = S_CSUM;
            end
            S_CSUM: begin
                if (last_byte)
                    state_nxt = (word == acc) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (reload)
                    state_nxt = S_LEN;
            end
            default: state_nxt = S_LEN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_LEN;
            byte_cnt     <= 2'd0;
            partial      <= 24'd0;
            len          <= 32'd0;
            acc          <= 32'd0;
            words_loaded <= 32'd0;
            mem_wen      <= 1'b0;
            mem_waddr    <= 32'd0;
            mem_wdata    <= 32'd0;
            cpu_run      <= 1'b0;
            error        <= 1'b0;
        end else begin
            state   <= state_nxt;
            mem_wen <= 1'b0;

            // Counter restarts on any state change so each phase begins at byte 0.
            if (state_nxt != state)
                byte_cnt <= 2'd0;
            else if (take)
                byte_cnt <= byte_cnt + 2'd1;

            if (take) begin
                case (byte_cnt)
                    2'd0:    partial[7:0]   <= in_data;
                    2'd1:    partial[15:8]  <= in_data;
                    2'd2:    partial[23:16] <= in_data;
                    default: ;
                endcase
            end

            if ((state == S_LEN) && last_byte)
                len <= word;

            if ((state == S_DATA) && last_byte) begin
                mem_wen      <= 1'b1;
                mem_waddr    <= BASE_W + words_loaded;
                mem_wdata    <= word;
                words_loaded <= words_loaded + 32'd1;
                acc          <= acc ^ word;
            end

            if (((state == S_DONE) || (state == S_ERROR)) && reload) begin
                words_loaded <= 32'd0;
                acc          <= 32'd0;
            end

            // Status outputs follow the state being entered, so they change on the deciding edge.
            cpu_run <= (state_nxt == S_DONE);
            error   <= (state_nxt == S_ERROR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: drives byte streams (directed and random, with random stalls)
// and compares every accepted byte's effect against a stream-level model of the load rules.
module tb_program_loader;

    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        reload;
    logic        mem_wen;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_run;
    logic        error;
    logic [31:0] words_loaded;

    program_loader #(.DEPTH(DEPTH), .BASE_ADDR(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .reload       (reload),
        .mem_wen      (mem_wen),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .cpu_run      (cpu_run),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_pass     = 0;
    int pulse_cnt  = 0;
    int exp_pulses = 0;

    logic [7:0] stream[$];

    always @(negedge clk) if (mem_wen === 1'b1) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic push_word(input logic [31:0] w);
        stream.push_back(w[7:0]);
        stream.push_back(w[15:8]);
        stream.push_back(w[23:16]);
        stream.push_back(w[31:24]);
    endtask

    task automatic build_random(input int nwords, input bit bad);
        logic [31:0] x;
        logic [31:0] w;
        x = 32'd0;
        stream.delete();
        push_word(32'(nwords));
        for (int k = 0; k < nwords; k++) begin
            w = $urandom;
            push_word(w);
            x ^= w;
        end
        if (bad) x ^= (32'd1 << $urandom_range(31, 0));
        push_word(x);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wen"},   {31'd0, mem_wen}, 32'd0);
        check({tag, "_waddr"}, mem_waddr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_run"},   {31'd0, cpu_run}, 32'd0);
        check({tag, "_err"},   {31'd0, error}, 32'd0);
        check({tag, "_wl"},    words_loaded, 32'd0);
        check({tag, "_rdy"},   {31'd0, in_ready}, 32'd1);
    endtask

    // Called at a falling edge; leaves at a falling edge.
    task automatic check_pulses(input string tag);
        #2;
        check(tag, 32'(pulse_cnt), 32'(exp_pulses));
        @(negedge clk);
    endtask

    // Sends the current stream (up to the bytes the loader should accept) and checks the
    // observable effect of each accepted byte against the load rules.
    task automatic run_load(input int stall_pct);
        logic [31:0] len_v, x, w, c;
        logic [31:0] e_wl, e_addr, e_data;
        logic        e_wen, e_run, e_err;
        int n_acc, nsend, di;

        len_v = {stream[3], stream[2], stream[1], stream[0]};
        n_acc = (len_v > 32'(DEPTH)) ? 4 : 8 + 4 * int'(len_v);
        nsend = (stream.size() < n_acc) ? stream.size() : n_acc;
        x = 32'd0;

        for (int i = 0; i < nsend; i++) begin
            while ($urandom_range(99, 0) < stall_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = stream[i];
            #1;
            check("in_ready_load", {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;

            e_wen = 1'b0; e_run = 1'b0; e_err = 1'b0;
            e_wl = 32'd0; e_addr = 32'd0; e_data = 32'd0;
            di = i - 4;
            if (i == 3 && len_v > 32'(DEPTH)) begin
                e_err = 1'b1;
            end else if (i >= 4 && di < 4 * int'(len_v)) begin
                e_wl = 32'((di + 1) / 4);
                if (di % 4 == 3) begin
                    w = {stream[i], stream[i-1], stream[i-2], stream[i-3]};
                    x ^= w;
                    e_wen  = 1'b1;
                    e_addr = 32'(di / 4);
                    e_data = w;
                end
            end else if (i >= 4) begin
                e_wl = len_v;
                if (i == 7 + 4 * int'(len_v)) begin
                    c = {stream[i], stream[i-1], stream[i-2], stream[i-3]};
                    e_run = (c == x);
                    e_err = !e_run;
                end
            end

            check("mem_wen", {31'd0, mem_wen}, {31'd0, e_wen});
            if (e_wen) begin
                exp_pulses++;
                check("mem_waddr", mem_waddr, e_addr);
                check("mem_wdata", mem_wdata, e_data);
            end
            check("words_loaded", words_loaded, e_wl);
            check("cpu_run", {31'd0, cpu_run}, {31'd0, e_run});
            check("error", {31'd0, error}, {31'd0, e_err});
        end

        if (nsend == n_acc) begin
            check("rdy_after_load", {31'd0, in_ready}, 32'd0);
            // Further bytes must be ignored once the load has finished.
            in_valid = 1'b1;
            in_data  = 8'hA5;
            repeat (3) @(negedge clk);
            in_valid = 1'b0;
            check("run_hold", {31'd0, cpu_run}, {31'd0, e_run});
            check("err_hold", {31'd0, error}, {31'd0, e_err});
            check_pulses("pulse_count");
        end
    endtask

    task automatic do_reload(input bit with_valid);
        in_valid = with_valid;
        in_data  = 8'h55;
        reload   = 1'b1;
        #1;
        if (with_valid) check("rdy_during_reload", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reload   = 1'b0;
        in_valid = 1'b0;
        check("reload_run", {31'd0, cpu_run}, 32'd0);
        check("reload_err", {31'd0, error}, 32'd0);
        check("reload_wl",  words_loaded, 32'd0);
        check("reload_rdy", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        reload   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);

        // Nominal two-word load, valid held high.
        stream.delete();
        push_word(32'd2); push_word(32'h12345678); push_word(32'hDEADBEEF); push_word(32'hCC99E897);
        run_load(0);
        do_reload(0);

        // Same stream with random stalls.
        run_load(50);
        do_reload(0);

        // Bad checksum; reload attempted together with a valid byte.
        stream.delete();
        push_word(32'd2); push_word(32'h12345678); push_word(32'hDEADBEEF); push_word(32'hCD99E897);
        run_load(0);
        do_reload(1);

        // Oversize length.
        stream.delete();
        push_word(32'(DEPTH + 1));
        run_load(20);
        do_reload(0);

        // Zero length.
        stream.delete();
        push_word(32'd0); push_word(32'd0);
        run_load(0);
        do_reload(0);

        // Reset after 6 bytes of the nominal stream, then a full fresh load.
        stream.delete();
        push_word(32'd2); push_word(32'h12345678); push_word(32'hDEADBEEF); push_word(32'hCC99E897);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = stream[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_vals("midload_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_load(25);
        do_reload(0);

        // Single-word load after reload.
        stream.delete();
        push_word(32'd1); push_word(32'hAAAA5555); push_word(32'hAAAA5555);
        run_load(0);
        do_reload(0);

        // Random loads, some with a corrupted checksum.
        for (int r = 0; r < 8; r++) begin
            build_random($urandom_range(0, 5), ($urandom_range(0, 3) == 0));
            run_load(30);
            do_reload(0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
